// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register.
// Mode codes 6-7 are reserved and behave as a zero-length shift.
package shift_pkg;

    localparam logic [2:0] MODE_LOAD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ASR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shift/rotate unit.
// Non-shift modes pass the value through with out_bit low.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_serial_in,
    output logic [WIDTH-1:0] o_value,
    output logic             o_bit
);

    always_comb begin
        o_value = i_value;
        o_bit   = 1'b0;
        case (i_mode)
            MODE_SHL: begin
                o_value = {i_value[WIDTH-2:0], i_serial_in};
                o_bit   = i_value[WIDTH-1];
            end
            MODE_SHR: begin
                o_value = {i_serial_in, i_value[WIDTH-1:1]};
                o_bit   = i_value[0];
            end
            MODE_ASR: begin
                o_value = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
                o_bit   = i_value[0];
            end
            MODE_ROL: begin
                o_value = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
                o_bit   = i_value[WIDTH-1];
            end
            MODE_ROR: begin
                o_value = {i_value[0], i_value[WIDTH-1:1]};
                o_bit   = i_value[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_register_universal.sv
// WIDTH-bit universal shift register with parallel load and a
// start/busy/done interface that runs multi-bit shifts one bit per clock.
module shift_register_universal
    import shift_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {(WIDTH/2){2'b10}},
    localparam int              AMT_W       = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AMT_W-1:0] r_cnt;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_out;
    logic             r_sout;

    logic [WIDTH-1:0] w_step_val;
    logic             w_step_bit;
    logic             w_accept;
    logic             w_shift_cmd;
    logic             w_last;
    logic [AMT_W-1:0] w_amt_sat;

    assign w_accept    = start && (r_state != ST_SHIFT);
    assign w_amt_sat   = (amount > AMT_MAX) ? AMT_MAX : amount;
    assign w_shift_cmd = is_shift_mode(mode) && (w_amt_sat != '0);
    assign w_last      = (r_cnt == AMT_ONE);

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_mode     (r_mode),
        .i_value    (r_out),
        .i_serial_in(serial_in),
        .o_value    (w_step_val),
        .o_bit      (w_step_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_shift_cmd ? ST_SHIFT : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // An aborted edge performs no step; the partial value is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= RESET_VALUE;
            r_sout <= 1'b0;
            r_cnt  <= '0;
            r_mode <= MODE_LOAD;
        end else if (w_accept) begin
            if (mode == MODE_LOAD) begin
                r_out <= load_data;
            end
            r_mode <= mode;
            r_cnt  <= w_amt_sat;
        end else if ((r_state == ST_SHIFT) && !abort) begin
            r_out  <= w_step_val;
            r_sout <= w_step_bit;
            r_cnt  <= r_cnt - AMT_ONE;
        end
    end

    assign out        = r_out;
    assign serial_out = r_sout;
    assign busy       = (r_state == ST_SHIFT);
    assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_register_universal.sv
// Randomized bench for shift_register_universal (WIDTH=8) against a
// closed-form arithmetic model of each command.
module tb_shift_register_universal;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] mode = '0;
    logic [3:0] amount = '0;
    logic [7:0] load_data = '0;
    logic       serial_in = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] out;
    logic       serial_out;
    logic       busy;
    logic       done;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_out;
    logic       exp_sout;

    shift_register_universal #(
        .WIDTH      (8),
        .RESET_VALUE(8'hAA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .load_data (load_data),
        .serial_in (serial_in),
        .abort     (abort),
        .out       (out),
        .serial_out(serial_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Effect of n steps of mode m with a constant fill bit.
    function automatic void apply(input logic [2:0] m, input int n,
                                  input logic s, input logic [7:0] d);
        int          x;
        logic [15:0] w;
        if (m == MODE_LOAD) begin
            exp_out = d;
            return;
        end
        if (n == 0 || m > MODE_ROR) return;
        case (m)
            MODE_SHL: begin
                exp_sout = exp_out[8-n];
                x = (int'(exp_out) << n) | (s ? (1 << n) - 1 : 0);
                exp_out = x[7:0];
            end
            MODE_SHR: begin
                exp_sout = exp_out[n-1];
                x = (int'(exp_out) >> n) | (s ? (255 << (8 - n)) & 255 : 0);
                exp_out = x[7:0];
            end
            MODE_ASR: begin
                exp_sout = exp_out[n-1];
                exp_out = 8'($signed(exp_out) >>> n);
            end
            MODE_ROL: begin
                w = {exp_out, exp_out} << n;
                exp_out = w[15:8];
                exp_sout = exp_out[0];
            end
            default: begin
                w = {exp_out, exp_out} >> n;
                exp_out = w[7:0];
                exp_sout = exp_out[7];
            end
        endcase
    endfunction

    // Issue one command; abort_at>0 raises abort in that busy cycle.
    task automatic do_op(input logic [2:0] m, input int amt,
                         input logic [7:0] d, input logic s,
                         input int abort_at, input bit poke);
        int n, steps, lat, nbusy, ndone;
        n = (m == MODE_LOAD || m > MODE_ROR) ? 0 : (amt > 8 ? 8 : amt);
        steps = (abort_at > 0) ? abort_at - 1 : n;
        lat = 0;
        nbusy = 0;
        start = 1'b1;
        mode = m;
        amount = 4'(amt);
        load_data = d;
        serial_in = s;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 3'($urandom);
        amount = 4'($urandom);
        load_data = 8'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) nbusy++;
            if (abort_at == k) abort = 1'b1;
            if (poke && k == 2) begin
                start = 1'b1;
                mode = MODE_LOAD;
                load_data = 8'h00;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            if (abort_at == k) break;
        end
        apply(m, steps, s, d);
        chk("out", out, exp_out);
        chk("serial_out", serial_out, exp_sout);
        if (abort_at > 0) begin
            chk("abort_lat", lat, 0);
            chk("abort_busy", busy, 0);
            ndone = 0;
            repeat (3) begin
                if (done) ndone++;
                @(posedge clk); #1;
            end
            chk("abort_done", ndone, 0);
        end else begin
            chk("latency", lat, n + 1);
            chk("busy_cycles", nbusy, n);
            @(posedge clk); #1;
            chk("done_1cyc", done, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        int pulses;
        int m, amt, ab, n;
        bit pk;
        #3 rst = 1'b1;
        #1;
        chk("rst_out", out, 8'hAA);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sout", serial_out, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_out = 8'hAA;
        exp_sout = 1'b0;

        do_op(MODE_LOAD, 0, 8'h81, 1'b0, 0, 1'b0);
        do_op(MODE_SHL, 3, 8'h00, 1'b1, 0, 1'b0);
        chk("shl3_val", out, 8'h0F);
        do_op(MODE_LOAD, 0, 8'h80, 1'b0, 0, 1'b0);
        do_op(MODE_ASR, 3, 8'h00, 1'b1, 0, 1'b0);
        chk("asr3_val", out, 8'hF0);
        do_op(MODE_LOAD, 0, 8'h80, 1'b0, 0, 1'b0);
        do_op(MODE_SHR, 3, 8'h00, 1'b0, 0, 1'b0);
        chk("shr3_val", out, 8'h10);
        do_op(MODE_LOAD, 0, 8'h96, 1'b0, 0, 1'b0);
        do_op(MODE_ROR, 12, 8'h00, 1'b0, 0, 1'b1);
        chk("ror_sat_val", out, 8'h96);
        do_op(MODE_ROL, 0, 8'h00, 1'b0, 0, 1'b0);
        do_op(3'd6, 5, 8'h00, 1'b0, 0, 1'b0);
        do_op(MODE_LOAD, 0, 8'h01, 1'b0, 0, 1'b0);
        do_op(MODE_SHL, 5, 8'h00, 1'b0, 3, 1'b0);
        chk("abort_val", out, 8'h04);

        // Back-to-back: ROL 1 accepted in the LOAD's done cycle.
        pulses = 0;
        start = 1'b1;
        mode = MODE_LOAD;
        load_data = 8'h81;
        @(posedge clk); #1;
        if (done) pulses++;
        mode = MODE_ROL;
        amount = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        apply(MODE_LOAD, 0, 1'b0, 8'h81);
        apply(MODE_ROL, 1, 1'b0, 8'h00);
        chk("b2b_pulses", pulses, 2);
        chk("b2b_out", out, exp_out);
        chk("b2b_sout", serial_out, exp_sout);

        // Asynchronous reset in the middle of a shift.
        start = 1'b1;
        mode = MODE_SHL;
        amount = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", out, 8'hAA);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sout", serial_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_out = 8'hAA;
        exp_sout = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_done", done, 0);

        for (int i = 0; i < 60; i++) begin
            m = $urandom_range(0, 7);
            amt = $urandom_range(0, 15);
            n = (m == 0 || m > 5) ? 0 : (amt > 8 ? 8 : amt);
            ab = 0;
            pk = 1'b0;
            if (n >= 2 && $urandom_range(0, 4) == 0) begin
                ab = $urandom_range(1, n);
            end else if (n >= 3 && $urandom_range(0, 2) == 0) begin
                pk = 1'b1;
            end
            do_op(3'(m), amt, 8'($urandom), 1'($urandom), ab, pk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
